rv_decode_stage: RTL and testbench

//  Registered RV integer decode stage with valid/ready handshake, generalised to XLEN.

---
 rtl/rv_decode_stage.sv | 245 ++++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// Registered RV integer decode stage (OP, OP-IMM, BRANCH, LUI) with a valid/ready handshake.
// Define DECODE_SKID_EN to add a 1-entry skid buffer so that in_ready is a pure register output.
module rv_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      alu_op,
  output logic            use_imm,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            is_branch,
  output logic [2:0]      br_cond,
  output logic            illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("rv_decode_stage: XLEN must be 32 or 64");
  end

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;

  typedef struct packed {
    alu_op_e         alu_op;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic            is_branch;
    logic [2:0]      br_cond;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } dec_t;

  // Register-register and non-shift immediate ops share one funct3 mapping.
  function automatic alu_op_e base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu = ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic            slli_ok;
  logic            srxi_ok;

  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_b  = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};

  // The shift amount is one bit wider at XLEN=64, so one fewer upper bit must be zero.
  if (XLEN == 64) begin : g_shamt64
    assign slli_ok = (in_inst[31:26] == 6'b0);
    assign srxi_ok = ({in_inst[31], in_inst[29:26]} == 5'b0);
  end else begin : g_shamt32
    assign slli_ok = (in_inst[31:25] == 7'b0);
    assign srxi_ok = ({in_inst[31], in_inst[29:25]} == 6'b0);
  end

  dec_t dec;
  logic dec_ok;
  logic dec_wr;

  // NOTE: every variable assigned below gets a default first so no latch is inferred.
  always_comb begin
    dec     = '0;
    dec_ok  = 1'b0;
    dec_wr  = 1'b0;
    dec.rs1 = in_inst[19:15];
    dec.rs2 = in_inst[24:20];
    dec.rd  = in_inst[11:7];
    dec.pc  = in_pc;
    if (in_inst[1:0] == 2'b11) begin
      case (in_inst[6:2])
        OPC_OP: begin
          dec_wr = 1'b1;
          if (funct7 == 7'b0000000) begin
            dec_ok     = 1'b1;
            dec.alu_op = base_alu(funct3);
          end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
            dec_ok     = 1'b1;
            dec.alu_op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
          end
        end
        OPC_OP_IMM: begin
          dec_wr      = 1'b1;
          dec.use_imm = 1'b1;
          dec.imm     = imm_i;
          case (funct3)
            3'b001: begin
              dec_ok     = slli_ok;
              dec.alu_op = ALU_SLL;
            end
            3'b101: begin
              dec_ok     = srxi_ok;
              dec.alu_op = in_inst[30] ? ALU_SRA : ALU_SRL;
            end
            default: begin
              dec_ok     = 1'b1;
              dec.alu_op = base_alu(funct3);
            end
          endcase
        end
        OPC_BRANCH: begin
          dec_ok        = (funct3 != 3'b010) && (funct3 != 3'b011);
          dec.alu_op    = ALU_SUB;
          dec.imm       = imm_b;
          dec.is_branch = 1'b1;
          dec.br_cond   = funct3;
        end
        OPC_LUI: begin
          dec_ok      = 1'b1;
          dec_wr      = 1'b1;
          dec.alu_op  = ALU_PASSB;
          dec.use_imm = 1'b1;
          dec.imm     = imm_u;
        end
        default: dec_ok = 1'b0;
      endcase
    end
    if (dec_ok) begin
      dec.rd_we = dec_wr && (dec.rd != 5'd0);
    end else begin
      dec.alu_op    = ALU_ADD;
      dec.use_imm   = 1'b0;
      dec.imm       = '0;
      dec.rd_we     = 1'b0;
      dec.is_branch = 1'b0;
      dec.br_cond   = 3'b0;
      dec.illegal   = 1'b1;
    end
  end

  dec_t out_q;
  logic in_fire;

  assign in_fire = in_valid && in_ready;

`ifdef DECODE_SKID_EN
  dec_t skid_q;
  logic skid_full;

  assign in_ready = !skid_full;

  // The skid entry is older than anything arriving, so it always refills the output first.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      skid_full <= 1'b0;
      skid_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_full) begin
        out_q     <= skid_q;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else if (in_fire) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q    <= dec;
      skid_full <= 1'b1;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  // NOTE: state updates use nonblocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_q     <= dec;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign out_pc    = out_q.pc;
  assign alu_op    = out_q.alu_op;
  assign use_imm   = out_q.use_imm;
  assign imm       = out_q.imm;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign rd_we     = out_q.rd_we;
  assign is_branch = out_q.is_branch;
  assign br_cond   = out_q.br_cond;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: XLEN=32 and XLEN=64 instances share stimulus; a queue scoreboard
// checks every delivered instruction against a hand-written vector table.
module tb_rv_decode_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready32, out_valid32, use_imm32, rd_we32, is_branch32, illegal32;
  logic [31:0] out_pc32, imm32;
  logic [3:0]  alu_op32;
  logic [4:0]  rs1_32, rs2_32, rd_32;
  logic [2:0]  br_cond32;

  logic        in_ready64, out_valid64, use_imm64, rd_we64, is_branch64, illegal64;
  logic [31:0] out_pc64;
  logic [63:0] imm64;
  logic [3:0]  alu_op64;
  logic [4:0]  rs1_64, rs2_64, rd_64;
  logic [2:0]  br_cond64;

  rv_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32),
    .alu_op(alu_op32), .use_imm(use_imm32), .imm(imm32),
    .rs1(rs1_32), .rs2(rs2_32), .rd(rd_32), .rd_we(rd_we32),
    .is_branch(is_branch32), .br_cond(br_cond32), .illegal(illegal32)
  );

  rv_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
    .alu_op(alu_op64), .use_imm(use_imm64), .imm(imm64),
    .rs1(rs1_64), .rs2(rs2_64), .rd(rd_64), .rd_we(rd_we64),
    .is_branch(is_branch64), .br_cond(br_cond64), .illegal(illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  alu;
    logic        ui;
    logic [63:0] imm;
    logic        we;
    logic        br;
    logic [2:0]  cond;
    logic        ill32;
    logic        ill64;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
  } exp_t;

  localparam int NV = 18;
  vec_t vecs[NV];
  exp_t sb[$];

  int          checks = 0;
  int          errors = 0;
  int          cur_idx = 0;
  logic [31:0] pc_next = 32'h1000;
  logic        rand_stall = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (bound expired)", name);
  endtask

  function automatic vec_t mk(input logic [31:0] inst, input logic [3:0] alu, input logic ui,
                              input logic [63:0] im, input logic we, input logic br,
                              input logic [2:0] cond, input logic ill32, input logic ill64);
    vec_t v;
    v.inst = inst; v.alu = alu; v.ui = ui; v.imm = im; v.we = we;
    v.br = br; v.cond = cond; v.ill32 = ill32; v.ill64 = ill64;
    return v;
  endfunction

  function automatic logic [127:0] exp_pack(input vec_t v, input logic [31:0] pc, input bit is64);
    logic [63:0] im;
    logic        ill;
    ill = is64 ? v.ill64 : v.ill32;
    im  = is64 ? v.imm : {32'b0, v.imm[31:0]};
    if (ill)
      return {6'b0, 4'b0, 1'b0, 64'b0, 1'b0, 1'b0, 3'b0, 1'b1,
              v.inst[19:15], v.inst[24:20], v.inst[11:7], pc};
    return {6'b0, v.alu, v.ui, im, v.we, v.br, v.cond, 1'b0,
            v.inst[19:15], v.inst[24:20], v.inst[11:7], pc};
  endfunction

  logic [127:0] got32, got64;
  assign got32 = {6'b0, alu_op32, use_imm32, 32'b0, imm32, rd_we32, is_branch32, br_cond32,
                  illegal32, rs1_32, rs2_32, rd_32, out_pc32};
  assign got64 = {6'b0, alu_op64, use_imm64, imm64, rd_we64, is_branch64, br_cond64,
                  illegal64, rs1_64, rs2_64, rd_64, out_pc64};

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  logic         prev_stall = 1'b0;
  logic [127:0] prev_got32 = '0;
  logic [127:0] prev_got64 = '0;
  exp_t         e;

  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_hold_x32", {127'b0, out_valid32} ^ (got32 << 1), {127'b0, 1'b1} ^ (prev_got32 << 1));
      check("stall_hold_x64", got64, prev_got64);
    end
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid32 && out_ready) begin
        if (sb.size() == 0) begin
          fail("unexpected_output");
        end else begin
          e = sb.pop_front();
          check($sformatf("vec%0d_x32", e.idx), got32, exp_pack(vecs[e.idx], e.pc, 1'b0));
          check($sformatf("vec%0d_x64", e.idx), {got64[127:1], out_valid64},
                {exp_pack(vecs[e.idx], e.pc, 1'b1) | 128'b1});
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready32) sb.push_back('{cur_idx, in_pc});
    end
    prev_stall = out_valid32 && !out_ready && !flush && !reset;
    prev_got32 = got32;
    prev_got64 = got64;
  end

  task automatic send(input int idx);
    int n;
    n        = 0;
    cur_idx  = idx;
    in_inst  = vecs[idx].inst;
    in_pc    = pc_next;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready32 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready32) fail("send_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pc_next  = pc_next + 32'd4;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid32) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0 || out_valid32) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(32'h00500093, 4'd0,  1'b1, 64'd5,                  1'b1, 1'b0, 3'd0, 1'b0, 1'b0); // addi x1,x0,5
    vecs[1]  = mk(32'h40208033, 4'd1,  1'b0, 64'd0,                  1'b0, 1'b0, 3'd0, 1'b0, 1'b0); // sub x0,x1,x2
    vecs[2]  = mk(32'h00000000, 4'd0,  1'b0, 64'd0,                  1'b0, 1'b0, 3'd0, 1'b1, 1'b1); // all zero
    vecs[3]  = mk(32'hFE000EE3, 4'd1,  1'b0, 64'hFFFFFFFFFFFFFFFC,   1'b0, 1'b1, 3'd0, 1'b0, 1'b0); // beq -4
    vecs[4]  = mk(32'h123452B7, 4'd10, 1'b1, 64'h0000000012345000,   1'b1, 1'b0, 3'd0, 1'b0, 1'b0); // lui x5
    vecs[5]  = mk(32'h02009093, 4'd2,  1'b1, 64'd32,                 1'b1, 1'b0, 3'd0, 1'b1, 1'b0); // slli x1,x1,32
    vecs[6]  = mk(32'h0020C1B3, 4'd5,  1'b0, 64'd0,                  1'b1, 1'b0, 3'd0, 1'b0, 1'b0); // xor x3,x1,x2
    vecs[7]  = mk(32'hFFF0E213, 4'd8,  1'b1, 64'hFFFFFFFFFFFFFFFF,   1'b1, 1'b0, 3'd0, 1'b0, 1'b0); // ori x4,x1,-1
    vecs[8]  = mk(32'h07F17293, 4'd9,  1'b1, 64'h7F,                 1'b1, 1'b0, 3'd0, 1'b0, 1'b0); // andi x5,x2,127
    vecs[9]  = mk(32'h4030D313, 4'd7,  1'b1, 64'h403,                1'b1, 1'b0, 3'd0, 1'b0, 1'b0); // srai x6,x1,3
    vecs[10] = mk(32'h0020E463, 4'd1,  1'b0, 64'd8,                  1'b0, 1'b1, 3'd6, 1'b0, 1'b0); // bltu +8
    vecs[11] = mk(32'h0020A463, 4'd0,  1'b0, 64'd0,                  1'b0, 1'b0, 3'd0, 1'b1, 1'b1); // branch f3=010
    vecs[12] = mk(32'h40209033, 4'd0,  1'b0, 64'd0,                  1'b0, 1'b0, 3'd0, 1'b1, 1'b1); // f7=0100000 f3=001
    vecs[13] = mk(32'h4020D3B3, 4'd7,  1'b0, 64'd0,                  1'b1, 1'b0, 3'd0, 1'b0, 1'b0); // sra x7,x1,x2
    vecs[14] = mk(32'h8000D313, 4'd0,  1'b0, 64'd0,                  1'b0, 1'b0, 3'd0, 1'b1, 1'b1); // srli bit31 set
    vecs[15] = mk(32'h80000137, 4'd10, 1'b1, 64'hFFFFFFFF80000000,   1'b1, 1'b0, 3'd0, 1'b0, 1'b0); // lui x2,0x80000
    vecs[16] = mk(32'h00500091, 4'd0,  1'b0, 64'd0,                  1'b0, 1'b0, 3'd0, 1'b1, 1'b1); // [1:0]=01
    vecs[17] = mk(32'h0020B433, 4'd4,  1'b0, 64'd0,                  1'b1, 1'b0, 3'd0, 1'b0, 1'b0); // sltu x8,x1,x2

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", {126'b0, out_valid32, out_valid64}, 128'd0);
    check("reset_out_x32", got32, 128'd0);
    check("reset_out_x64", got64, 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {126'b0, in_ready32, in_ready64}, 128'd3);

    // Full-throughput pass with the consumer always ready.
    @(posedge clk); #1;
    for (int i = 0; i < NV; i++) send(i);
    drain();

    // Same table under an intermittently stalling consumer.
    rand_stall = 1'b1;
    fork
      begin
        while (rand_stall) begin
          @(posedge clk); #1;
          if (rand_stall) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = NV - 1; i >= 0; i--) send(i);
    rand_stall = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    // Three back-to-back inputs against a three-cycle stall.
    out_ready = 1'b0;
    fork
      begin send(0); send(6); send(4); end
      begin repeat (3) @(posedge clk); #1 out_ready = 1'b1; end
      begin
        @(posedge clk);
`ifdef DECODE_SKID_EN
        @(posedge clk);
`endif
        @(negedge clk);
        check("stall_in_ready", {127'b0, in_ready32}, 128'd0);
      end
    join
    drain();

    // Flush with output valid, second instruction held, and a new input presented.
    out_ready = 1'b0;
    cur_idx = 0; in_inst = vecs[0].inst; in_pc = pc_next; in_valid = 1'b1;
    @(posedge clk); #1;
    pc_next = pc_next + 32'd4;
    cur_idx = 3; in_inst = vecs[3].inst; in_pc = pc_next;
    @(posedge clk); #1;
    pc_next = pc_next + 32'd4;
    cur_idx = 4; in_inst = vecs[4].inst; in_pc = pc_next; flush = 1'b1;
    @(negedge clk);
    check("pre_flush_state", {126'b0, out_valid32, in_ready32}, 128'd2);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("post_flush_state", {126'b0, out_valid32, in_ready32}, 128'd1);
    repeat (4) @(negedge clk);
    check("flush_nothing_delivered", {127'b0, out_valid32}, 128'd0);

    // Flush wins over a handshake in the same cycle.
    @(posedge clk); #1;
    cur_idx = 7; in_inst = vecs[7].inst; in_pc = pc_next; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_beats_accept", {127'b0, out_valid32}, 128'd0);

    // Reset together with flush while a stalled instruction is held.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(15);
    reset = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("reset_flush_x32", {got32[127:1], out_valid32}, 128'd0);
    check("reset_flush_x64", got64, 128'd0);
    check("reset_flush_ready", {127'b0, in_ready32}, 128'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_flush_idle", {127'b0, out_valid32}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
